// File: rtl/gan_pkg.sv
// rtl/gan_pkg.sv - shared constants, layer tables and FSM state type for the GAN layer sequencer
package gan_pkg;

  localparam int N_LAYERS  = 8;
  localparam int N_NEURONS = 19;
  localparam int N_W       = 54;
  localparam int N_B       = 19;
  localparam int MAX_FAN   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Operands per neuron in each layer (the previous layer's width).
  function automatic logic [2:0] fan_in_of(input logic [2:0] layer);
    case (layer)
      3'd0:    return 3'd4;
      3'd1:    return 3'd4;
      3'd2:    return 3'd2;
      3'd3:    return 3'd1;
      3'd4:    return 3'd1;
      3'd5:    return 3'd1;
      3'd6:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Neurons computed in each layer.
  function automatic logic [2:0] neurons_of(input logic [2:0] layer);
    case (layer)
      3'd0:    return 3'd4;
      3'd1:    return 3'd2;
      3'd2:    return 3'd1;
      3'd3:    return 3'd1;
      3'd4:    return 3'd1;
      3'd5:    return 3'd2;
      3'd6:    return 3'd4;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/gan_act_pingpong.sv
// rtl/gan_act_pingpong.sv - current/next activation buffers with result merge, layer swap and operand masking
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   load_i, x_i     load x_i into the current buffer and clear the next buffer
//   wr_i, idx_i,    write data_i into next-buffer entry idx_i
//   data_i
//   swap_i          with wr_i: current <= next (including this write), next cleared
//   fan_in_i        operands in use; current entries at index >= fan_in_i read as 0
//   job_x_o         masked operand vector for the neuron unit
//   merged_o        next buffer with the pending write applied
module gan_act_pingpong
  import gan_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic [4*WIDTH-1:0] x_i,
  input  logic               wr_i,
  input  logic [1:0]         idx_i,
  input  logic [WIDTH-1:0]   data_i,
  input  logic               swap_i,
  input  logic [2:0]         fan_in_i,
  output logic [4*WIDTH-1:0] job_x_o,
  output logic [4*WIDTH-1:0] merged_o
);

  logic [3:0][WIDTH-1:0] cur_q;
  logic [3:0][WIDTH-1:0] nxt_q;
  logic [3:0][WIDTH-1:0] merged;
  logic [3:0][WIDTH-1:0] job_x;

  always_comb begin
    merged = nxt_q;
    if (wr_i) begin
      merged[idx_i] = data_i;
    end
  end

  always_comb begin
    job_x = '0;
    for (int i = 0; i < MAX_FAN; i++) begin
      if (3'(i) < fan_in_i) begin
        job_x[i] = cur_q[i];
      end
    end
  end

  assign job_x_o  = job_x;
  assign merged_o = merged;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q <= '0;
      nxt_q <= '0;
    end else if (load_i) begin
      cur_q <= x_i;
      nxt_q <= '0;
    end else if (wr_i) begin
      if (swap_i) begin
        cur_q <= merged;
        nxt_q <= '0;
      end else begin
        nxt_q <= merged;
      end
    end
  end

endmodule

// File: rtl/gan_layer_sequencer.sv
// rtl/gan_layer_sequencer.sv - sequences the 19 neuron jobs of an 8-layer GAN generator through one shared neuron unit
// Optional feature macro: GAN_SEQ_TIMEOUT_EN (WAIT watchdog of TIMEOUT_CYCLES cycles).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, x_in           start inference with input vector x_in (sampled in IDLE only)
//   busy, done, y_out     run in progress, one-cycle completion pulse, final activations
//   job_valid/job_ready   job handshake; job_fan_in, job_w_base, job_b_addr, job_x describe the job
//   res_valid, res_data   post-ReLU result strobe from the neuron unit
//   err                   sticky protocol error, cleared on accepted start
module gan_layer_sequencer
  import gan_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [4*WIDTH-1:0] x_in,
  output logic               busy,
  output logic               done,
  output logic [4*WIDTH-1:0] y_out,
  output logic               job_valid,
  input  logic               job_ready,
  output logic [2:0]         job_fan_in,
  output logic [5:0]         job_w_base,
  output logic [4:0]         job_b_addr,
  output logic [4*WIDTH-1:0] job_x,
  input  logic               res_valid,
  input  logic [WIDTH-1:0]   res_data,
  output logic               err
);

  state_e             state_q, state_d;
  logic [2:0]         layer_q, layer_d;
  logic [1:0]         neuron_q, neuron_d;
  logic [5:0]         w_ptr_q, w_ptr_d;
  logic [4:0]         b_ptr_q, b_ptr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               job_valid_q, job_valid_d;
  logic               err_q, err_d;
  logic [4*WIDTH-1:0] y_out_q, y_out_d;

  logic               pp_load, pp_wr, pp_swap;
  logic [4*WIDTH-1:0] pp_job_x, pp_merged;
  logic [2:0]         fan_in;
  logic               last_neuron;

  assign fan_in      = fan_in_of(layer_q);
  assign last_neuron = ({1'b0, neuron_q} == (neurons_of(layer_q) - 3'd1));

`ifdef GAN_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
`endif

  gan_act_pingpong #(.WIDTH(WIDTH)) u_act (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (pp_load),
    .x_i      (x_in),
    .wr_i     (pp_wr),
    .idx_i    (neuron_q),
    .data_i   (res_data),
    .swap_i   (pp_swap),
    .fan_in_i (fan_in),
    .job_x_o  (pp_job_x),
    .merged_o (pp_merged)
  );

  always_comb begin
    state_d     = state_q;
    layer_d     = layer_q;
    neuron_d    = neuron_q;
    w_ptr_d     = w_ptr_q;
    b_ptr_d     = b_ptr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    job_valid_d = job_valid_q;
    err_d       = err_q;
    y_out_d     = y_out_q;
    pp_load     = 1'b0;
    pp_wr       = 1'b0;
    pp_swap     = 1'b0;
`ifdef GAN_SEQ_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif

    // A result can only be legitimately consumed in WAIT; anywhere else it
    // is discarded and flagged. An accepted start below overrides the flag.
    if (res_valid && (state_q != ST_WAIT)) begin
      err_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pp_load     = 1'b1;
          layer_d     = '0;
          neuron_d    = '0;
          w_ptr_d     = '0;
          b_ptr_d     = '0;
          err_d       = 1'b0;
          busy_d      = 1'b1;
          job_valid_d = 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (job_ready) begin
          job_valid_d = 1'b0;
          state_d     = ST_WAIT;
`ifdef GAN_SEQ_TIMEOUT_EN
          tmo_d       = '0;
`endif
        end
      end
      ST_WAIT: begin
        if (res_valid) begin
          pp_wr   = 1'b1;
          w_ptr_d = w_ptr_q + {3'b000, fan_in};
          b_ptr_d = b_ptr_q + 5'd1;
          if (last_neuron) begin
            pp_swap  = 1'b1;
            neuron_d = '0;
            if (layer_q == 3'(N_LAYERS - 1)) begin
              y_out_d = pp_merged;
              done_d  = 1'b1;
              state_d = ST_DONE;
            end else begin
              layer_d     = layer_q + 3'd1;
              job_valid_d = 1'b1;
              state_d     = ST_ISSUE;
            end
          end else begin
            neuron_d    = neuron_q + 2'd1;
            job_valid_d = 1'b1;
            state_d     = ST_ISSUE;
          end
        end
`ifdef GAN_SEQ_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      layer_q     <= '0;
      neuron_q    <= '0;
      w_ptr_q     <= '0;
      b_ptr_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      job_valid_q <= 1'b0;
      err_q       <= 1'b0;
      y_out_q     <= '0;
    end else begin
      state_q     <= state_d;
      layer_q     <= layer_d;
      neuron_q    <= neuron_d;
      w_ptr_q     <= w_ptr_d;
      b_ptr_q     <= b_ptr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      job_valid_q <= job_valid_d;
      err_q       <= err_d;
      y_out_q     <= y_out_d;
    end
  end

`ifdef GAN_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  // Job fields come straight from registers that only move outside ISSUE,
  // so they stay stable under backpressure; they read 0 when no job is offered.
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign y_out      = y_out_q;
  assign job_valid  = job_valid_q;
  assign job_fan_in = job_valid_q ? fan_in   : '0;
  assign job_w_base = job_valid_q ? w_ptr_q  : '0;
  assign job_b_addr = job_valid_q ? b_ptr_q  : '0;
  assign job_x      = job_valid_q ? pp_job_x : '0;

endmodule
